// File: rtl/temp_ascii_fmt_pkg.sv
// Shared types, ASCII constants and the double-dabble step used by the
// temperature-to-ASCII formatter.
package temp_ascii_fmt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam int TEMP_W    = 12;
  localparam int FIELD_LEN = 8;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_DOT   = 8'h2E;
  localparam logic [7:0] ASC_SPACE = 8'h20;

  // One shift-add-3 iteration on {hundreds, tens, ones, binary[7:0]}.
  function automatic logic [19:0] dd_step(input logic [19:0] sr);
    logic [19:0] t;
    t = sr;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/temp_ascii_fmt_bcd.sv
// 8-bit sequential double-dabble: one iteration per clock, eight in total.
// The first iteration runs on the start edge (the BCD part is zero then,
// so it is a plain shift); o_done pulses the cycle the digits are final.
module bin8_to_bcd_seq
  import temp_ascii_fmt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_bin,
  output logic       o_done,
  output logic [3:0] o_hundreds,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  logic [19:0] r_sr;
  logic [3:0]  r_cnt;
  logic        r_done;

  // Load-and-first-step on start, then count the remaining seven steps down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_sr  <= dd_step({12'd0, i_bin});
        r_cnt <= 4'd7;
      end else if (r_cnt != 4'd0) begin
        r_sr  <= dd_step(r_sr);
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) r_done <= 1'b1;
      end
    end
  end

  assign o_done     = r_done;
  assign o_hundreds = r_sr[19:16];
  assign o_tens     = r_sr[15:12];
  assign o_ones     = r_sr[11:8];

endmodule

// File: rtl/temp_ascii_fmt.sv
// Formats a signed 12-bit temperature (LSB 1/16 degC) as "+ddd.d C" and
// streams the eight characters over a valid/ready handshake.
//   state   | meaning
//   ST_IDLE | waiting for a sample, temp_ready high
//   ST_CONV | integer part going through double-dabble
//   ST_SEND | streaming characters, index 0..7
module temp_ascii_fmt
  import temp_ascii_fmt_pkg::*;
#(
  parameter logic [7:0] UNIT_CHAR = 8'h43,
  parameter logic [7:0] PLUS_CHAR = 8'h2B
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              temp_valid,
  output logic              temp_ready,
  input  logic [TEMP_W-1:0] temp_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic [7:0]        char_data,
  output logic              char_last,
  output logic              busy
);

  state_e      r_state;
  logic        r_sign;
  logic [3:0]  r_tenths;
  logic [2:0]  r_idx;
  logic [7:0]  r_char_data;
  logic        r_char_valid;
  logic        r_char_last;
  logic        r_busy;
  logic        r_temp_ready;

  logic [TEMP_W-1:0] w_mag;
  logic [7:0]        w_frac10;
  logic [3:0]        w_tenths;
  logic              w_accept;
  logic              w_bcd_done;
  logic [3:0]        w_hund;
  logic [3:0]        w_tens;
  logic [3:0]        w_ones;

  // 12'h800 negates to itself, which reads correctly as unsigned 2048.
  assign w_mag    = temp_data[TEMP_W-1] ? -temp_data : temp_data;
  assign w_frac10 = {4'd0, w_mag[3:0]} * 8'd10;
  assign w_tenths = 4'(w_frac10 >> 4);
  assign w_accept = temp_valid && r_temp_ready && (r_state == ST_IDLE);

  bin8_to_bcd_seq u_bcd (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_accept),
    .i_bin      (w_mag[11:4]),
    .o_done     (w_bcd_done),
    .o_hundreds (w_hund),
    .o_tens     (w_tens),
    .o_ones     (w_ones)
  );

  function automatic logic [7:0] f_char(input logic [2:0] idx);
    case (idx)
      3'd0:    f_char = r_sign ? ASC_MINUS : PLUS_CHAR;
      3'd1:    f_char = ASC_ZERO + {4'd0, w_hund};
      3'd2:    f_char = ASC_ZERO + {4'd0, w_tens};
      3'd3:    f_char = ASC_ZERO + {4'd0, w_ones};
      3'd4:    f_char = ASC_DOT;
      3'd5:    f_char = ASC_ZERO + {4'd0, r_tenths};
      3'd6:    f_char = ASC_SPACE;
      default: f_char = UNIT_CHAR;
    endcase
  endfunction

  // Control FSM; every output is a register so char_data holds under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_sign       <= 1'b0;
      r_tenths     <= '0;
      r_idx        <= '0;
      r_char_data  <= 8'h00;
      r_char_valid <= 1'b0;
      r_char_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_temp_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_temp_ready <= 1'b1;
          if (w_accept) begin
            r_sign       <= temp_data[TEMP_W-1];
            r_tenths     <= w_tenths;
            r_temp_ready <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (w_bcd_done) begin
            r_state      <= ST_SEND;
            r_idx        <= 3'd0;
            r_char_data  <= f_char(3'd0);
            r_char_valid <= 1'b1;
            r_char_last  <= 1'b0;
          end
        end
        ST_SEND: begin
          if (r_char_valid && char_ready) begin
            if (r_idx == 3'(FIELD_LEN - 1)) begin
              r_state      <= ST_IDLE;
              r_char_valid <= 1'b0;
              r_char_last  <= 1'b0;
              r_busy       <= 1'b0;
              r_temp_ready <= 1'b1;
            end else begin
              r_idx       <= r_idx + 3'd1;
              r_char_data <= f_char(r_idx + 3'd1);
              r_char_last <= (r_idx == 3'(FIELD_LEN - 2));
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign temp_ready = r_temp_ready;
  assign char_valid = r_char_valid;
  assign char_data  = r_char_data;
  assign char_last  = r_char_last;
  assign busy       = r_busy;

endmodule

// File: doc/temp_ascii_fmt.md
# temp_ascii_fmt

Converts one signed 12-bit temperature sample (LSB = 0.0625 °C) into a fixed 8-character ASCII field such as "+025.0 C". Characters are streamed one per handshake to the downstream LCD character writer. Sits between the temperature sensor interface and the LCD controller. Integer-to-BCD conversion is sequential (shift-add-3) to keep the block small.

## Interface
Parameters:
- UNIT_CHAR, 8'h43 ('C'): ASCII code of the last character.
- PLUS_CHAR, 8'h2B ('+'): sign character for non-negative values; 8'h20 gives a blank.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- temp_valid  in  1  temp_data is offered.
- temp_ready  out  1  block accepts a sample; high only in IDLE.
- temp_data  in  12  two's-complement temperature, LSB 0.0625 °C.
- char_valid  out  1  char_data holds a valid character.
- char_ready  in  1  downstream accepts the character.
- char_data  out  8  ASCII character.
- char_last  out  1  high with the 8th character of a field.
- busy  out  1  high in CONV and SEND.

## Operation
- Reset values: temp_ready=0 during reset and 1 on the first cycle after it; char_valid=0, char_last=0, busy=0, char_data=8'h00. State=IDLE, char index=0.
- States: IDLE -> CONV -> SEND -> IDLE.
- IDLE:
  - temp_ready=1.
  - On temp_valid&&temp_ready, capture the sign (bit 11) and the magnitude mag = sign ? -temp_data : temp_data as 12-bit unsigned.
  - 12'h800 yields mag=2048; this is legal.
  - Go to CONV.
- Arithmetic:
  - int = mag[11:4] (0..128).
  - tenths = (mag[3:0]*10)>>4 (0..9), truncating.
  - Compute in 8-bit arithmetic, no rounding.
- CONV:
  - Double-dabble on int: 8 iterations, one per clock.
  - Each iteration: add 3 to any BCD nibble ≥5, then shift left by one.
  - Produces hundreds, tens and ones nibbles.
  - After the 8th iteration, go to SEND with index=0.
- SEND:
  - char_valid=1. The character for each index is:
    - 0: sign, '-' (8'h2D) or PLUS_CHAR.
    - 1: '0'+hundreds.
    - 2: '0'+tens.
    - 3: '0'+ones.
    - 4: '.' (8'h2E).
    - 5: '0'+tenths.
    - 6: ' ' (8'h20).
    - 7: UNIT_CHAR, with char_last=1.
  - No leading-zero blanking.
  - A transfer occurs on char_valid&&char_ready; index then increments.
  - The transfer at index 7 returns the block to IDLE.
- Negative zero cannot occur. Any non-negative value uses PLUS_CHAR; fractional negatives such as 12'hFFF print "-000.0 C".
- While busy, temp_valid is ignored and the sample is not queued.
- Synchronous reset in any state aborts the field immediately. Outputs take their reset values on the next edge, and no partial field resumes.

## Timing
- Cycle 0: input handshake. Cycles 1–8: CONV. Cycle 9: char_valid first high, with index 0.
- With char_ready tied high, one character transfers per cycle. char_last is high in cycle 16, and temp_ready is high again in cycle 17.
- Minimum spacing between accepted samples is 17 cycles.
- char_data and char_last are driven from registers and stay stable while char_valid&&!char_ready.
- char_valid never drops inside a field except on reset.
- temp_ready depends only on state; it has no combinational path from any input.

## Structure
- Shared package holds:
  - state encoding (ST_IDLE, ST_CONV, ST_SEND);
  - ASCII constants (ASC_ZERO, ASC_MINUS, ASC_DOT, ASC_SPACE);
  - FIELD_LEN=8 and TEMP_W=12.
- One sub-module is natural: bin8_to_bcd_seq. It is an 8-bit sequential double-dabble with start/done and three BCD nibble outputs, reusable for other numeric LCD fields.

## Test plan
- Input 12'h190 with char_ready=1 -> chars 2B 30 32 35 2E 30 20 43; char_last only on the 8th; first char_valid exactly 9 cycles after the input handshake.
- Input 12'hF5E (-10.125) -> "-010.1 C" (2D 30 31 30 2E 31 20 43).
- Boundaries: input 12'h800 -> "-128.0 C"; input 12'h7FF -> "+127.9 C"; input 12'h000 -> "+000.0 C"; input 12'hFFF -> "-000.0 C".
- Backpressure: input 12'h190, char_ready low for 5 cycles while index=3 -> char_data holds 8'h35 with char_valid high; field completes unchanged; a temp_valid pulse during SEND is dropped and temp_ready stays 0.
- Reset asserted in CONV and again in SEND at index 4 -> next cycle char_valid=0, busy=0, temp_ready=1; a following input 12'h190 produces a full, correct field.
- Back-to-back: temp_valid held high with two values -> second accepted in cycle 17; fields do not overlap.
